// File: rtl/msp430_ram_ctrl.sv
// -----------------------------------------------------------------------------
// msp430_ram_ctrl
//
// Initiator-side controller for the single-port MSP430 data RAM. It takes byte
// or word requests over a valid/ready handshake, performs one RAM access per
// legal request and returns exactly one response per request, in order.
// Illegal requests (out of range, or a misaligned word) get an error response
// and never touch the RAM.
//
// Ports
//   mclk, puc_rst          clock (shared with the RAM), sync active-high reset
//   req_valid/req_ready    request handshake
//   req_we, req_byte       1 = write / 1 = byte access
//   req_addr, req_wdata    byte address, write data (byte writes use [7:0])
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     read data (0 for writes/errors), error flag
//   ram_addr               RAM word address
//   ram_cen, ram_wen       RAM chip enable / per-byte write enables (low active)
//   ram_din, ram_dout      RAM write data / read data
// -----------------------------------------------------------------------------
module msp430_ram_ctrl #(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_byte,
    input  logic [15:0]         req_addr,
    input  logic [15:0]         req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [15:0]         rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [1:0]          ram_wen,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    localparam logic [15:0] WORDS = 16'(MEM_SIZE / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request attributes still needed once ram_dout comes back.
    logic        r_we;
    logic        r_byte;
    logic        r_lane;

    logic        w_accept;
    logic        w_req_err;
    logic [1:0]  w_wen;
    logic [15:0] w_din;
    logic [7:0]  w_byte_sel;

    // A pending response may be retired and a new request taken on the same
    // edge, so RESP also advertises ready while the response is being taken.
    assign req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready);
    assign w_accept  = req_valid & req_ready;

    assign w_req_err = ({1'b0, req_addr[15:1]} >= WORDS) | (~req_byte & req_addr[0]);

    assign w_wen = !req_we   ? 2'b11 :
                   !req_byte ? 2'b00 :
                   req_addr[0] ? 2'b01 : 2'b10;

    // Byte writes put the byte on both lanes; ram_wen picks the real one.
    assign w_din = req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;

    assign w_byte_sel = r_lane ? ram_dout[15:8] : ram_dout[7:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (puc_rst) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
            end
            S_ACCESS:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_accept)       w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
                else if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and request attributes
    // -------------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ram_cen   <= 1'b1;
            ram_wen   <= 2'b11;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_lane    <= 1'b0;
        end else begin
            // Strobes are one cycle wide: default them inactive every edge.
            ram_cen <= 1'b1;
            ram_wen <= 2'b11;

            if ((r_state == S_RESP) && rsp_ready) rsp_valid <= 1'b0;

            if (w_accept) begin
                r_we   <= req_we;
                r_byte <= req_byte;
                r_lane <= req_addr[0];
                if (w_req_err) begin
                    // Error responses skip the RAM and appear next cycle.
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end else begin
                    ram_cen  <= 1'b0;
                    ram_wen  <= w_wen;
                    ram_addr <= req_addr[ADDR_MSB+1:1];
                    if (req_we) ram_din <= w_din;
                end
            end

            // ram_dout is valid during CAPTURE; it becomes the response.
            if (r_state == S_CAPTURE) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= r_we   ? 16'h0000 :
                             r_byte ? {8'h00, w_byte_sel} : ram_dout;
            end
        end
    end

endmodule
